sprite_rom_arbiter: RTL
=======================

Name: sprite_rom_arbiter

Overview:
- Shares one on-chip sprite pixel ROM (SpriteX/SpriteY in, 24-bit RGB out, fixed read latency) among NUM_REQ object renderers (Mario, enemies, items) in the color-mapping path.
- Round-robin arbitration with a registered grant; the block issues one ROM lookup per cycle and returns tagged RGB after the ROM latency.
- Sits between the per-object renderers and the shared sprite ROM instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-ID width; must equal clog2(NUM_REQ).
- ROM_LAT, 2, ROM read latency in cycles (1..4).
- KEY_RGB, 24'hFF00FF, transparency key colour; used only with SPRITE_TRANSPARENCY_EN.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle pulse at vsync; resets the round-robin pointer.
- req  input  NUM_REQ  per-requester lookup request; level, held until granted.
- req_x  input  NUM_REQ*10  packed SpriteX per requester; requester i uses bits [10i+9:10i].
- req_y  input  NUM_REQ*10  packed SpriteY per requester, same packing.
- gnt  output  NUM_REQ  one-hot grant pulse.
- rom_x  output  10  SpriteX to ROM.
- rom_y  output  10  SpriteY to ROM.
- rom_rgb  input  24  ROM data {R,G,B}, valid ROM_LAT cycles after the address.
- rsp_valid  output  1  response valid.
- rsp_id  output  ID_W  requester owning the response.
- rsp_rgb  output  24  returned pixel.
- rsp_opaque  output  1  present only with SPRITE_TRANSPARENCY_EN.

Behaviour:
- Reset (async, active-high): gnt=0, rom_x=0, rom_y=0, rsp_valid=0, rsp_id=0, rsp_rgb=0, rsp_opaque=0, rr_ptr=0, all pipeline valid bits cleared. Lookups in flight are discarded.
- Arbitration, every cycle: search req starting at rr_ptr and wrapping modulo NUM_REQ. The first set bit k wins.
- Winner registration: gnt<=onehot(k), rom_x<=req_x[k], rom_y<=req_y[k], issue_valid<=1, issue_id<=k, rr_ptr<=(k+1) mod NUM_REQ.
- No request: gnt<=0, issue_valid<=0, rom_x/rom_y and rr_ptr hold.
- Requester contract: drop req, or present a new coordinate, the cycle after seeing gnt[i]=1. A req still high after gnt counts as a new request.
- Throughput: at most one grant per cycle. With all requesters active, each gets exactly one grant per NUM_REQ cycles.
- Pipeline: a shift register of ROM_LAT stages of {valid,id} carries each issue. rsp_valid/rsp_id come from its last stage. rsp_rgb <= rom_rgb is registered in the same cycle.
- Latency: req high at edge N gives gnt high after edge N+1, and rsp_valid high after edge N+1+ROM_LAT with matching rsp_id.
- Idle response: while rsp_valid=0, rsp_rgb holds its last value. There is no response backpressure; consumers capture on rsp_valid.
- frame_start: rr_ptr<=0 this cycle, overriding the winner-based update. The grant this cycle is still computed from the old rr_ptr. The pipeline is not flushed.
- Wrap-around: k=NUM_REQ-1 sets rr_ptr to 0.
- A req bit at or above NUM_REQ cannot exist; no X propagation on unused packed bits.

Optional Feature:
- Macro: SPRITE_TRANSPARENCY_EN.
- Defined: rsp_opaque port exists and is registered with rsp_rgb, asserted when rsp_valid=1 and rom_rgb!=KEY_RGB, else 0. Reset value 0.
- Undefined: the port and compare logic are absent; all other timing is identical.

Test Plan:
- Single requester: req=4'b0100, req_x=5, req_y=7, ROM models rgb=x*256+y with ROM_LAT=2. Expect gnt=4'b0100 one cycle later, rom_x=5, rom_y=7, and rsp_valid with rsp_id=2, rsp_rgb=24'h000507 two cycles after that.
- All four req held high for 8 cycles from reset: grant order 0,1,2,3,0,1,2,3, with rsp_id following the same sequence ROM_LAT cycles later and no gaps.
- req=4'b1001 with rr_ptr=1: grants 3 then 0 then 3. Pulse frame_start during the grant to 3: next grant goes to 0.
- Assert Reset asynchronously with two lookups in flight: all outputs read 0 immediately, and no rsp_valid appears after release.
- With SPRITE_TRANSPARENCY_EN: rom_rgb=24'hFF00FF gives rsp_opaque=0, rom_rgb=24'hFF0000 gives rsp_opaque=1. Without the macro, the build has no rsp_opaque port.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite pixel ROM among NUM_REQ object renderers.
// Optional SPRITE_TRANSPARENCY_EN adds KEY_RGB and the rsp_opaque output.
module sprite_rom_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned ROM_LAT = 2
`ifdef SPRITE_TRANSPARENCY_EN
   ,
   parameter logic [23:0] KEY_RGB = 24'hFF00FF
`endif
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  frame_start,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*10-1:0] req_x,
   input  logic [NUM_REQ*10-1:0] req_y,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [9:0]            rom_x,
   output logic [9:0]            rom_y,
   input  logic [23:0]           rom_rgb,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [23:0]           rsp_rgb
`ifdef SPRITE_TRANSPARENCY_EN
   ,
   output logic                  rsp_opaque
`endif
);

   logic [NUM_REQ-1:0] gntQ, gntD;
   logic [9:0]         romXQ, romYQ;
   logic [ID_W-1:0]    rrPtrQ, rrPtrD;
   logic [ID_W-1:0]    winId;
   logic               winFound;
   logic [ID_W:0]      scanIdx;
   logic [23:0]        rspRgbQ;

   // Stage 0 is the issue register; stage ROM_LAT drives the response.
   logic               validQ [0:ROM_LAT];
   logic [ID_W-1:0]    idQ    [0:ROM_LAT];

   // Scan from rrPtr; the extra scanIdx bit lets the wrap be a single subtract.
   always_comb begin
      winFound = 1'b0;
      winId    = '0;
      scanIdx  = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         scanIdx = {1'b0, rrPtrQ} + (ID_W+1)'(off);
         if (scanIdx >= (ID_W+1)'(NUM_REQ)) begin
            scanIdx = scanIdx - (ID_W+1)'(NUM_REQ);
         end
         if (!winFound && req[scanIdx[ID_W-1:0]]) begin
            winFound = 1'b1;
            winId    = scanIdx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      gntD = '0;
      if (winFound) begin
         gntD[winId] = 1'b1;
      end
      rrPtrD = rrPtrQ;
      if (frame_start) begin
         rrPtrD = '0;
      end else if (winFound) begin
         rrPtrD = (winId == ID_W'(NUM_REQ - 1)) ? '0 : winId + ID_W'(1);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         gntQ    <= '0;
         romXQ   <= '0;
         romYQ   <= '0;
         rrPtrQ  <= '0;
         rspRgbQ <= '0;
         for (int unsigned i = 0; i <= ROM_LAT; i++) begin
            validQ[i] <= 1'b0;
            idQ[i]    <= '0;
         end
      end else begin
         gntQ      <= gntD;
         rrPtrQ    <= rrPtrD;
         validQ[0] <= winFound;
         if (winFound) begin
            idQ[0] <= winId;
            romXQ  <= req_x[10*winId +: 10];
            romYQ  <= req_y[10*winId +: 10];
         end
         for (int unsigned i = 1; i <= ROM_LAT; i++) begin
            validQ[i] <= validQ[i-1];
            idQ[i]    <= idQ[i-1];
         end
         // Capture ROM data on the same edge the response becomes valid.
         if (validQ[ROM_LAT-1]) begin
            rspRgbQ <= rom_rgb;
         end
      end
   end

`ifdef SPRITE_TRANSPARENCY_EN
   logic rspOpaqueQ;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rspOpaqueQ <= 1'b0;
      end else begin
         rspOpaqueQ <= validQ[ROM_LAT-1] && (rom_rgb != KEY_RGB);
      end
   end

   assign rsp_opaque = rspOpaqueQ;
`endif

   assign gnt       = gntQ;
   assign rom_x     = romXQ;
   assign rom_y     = romYQ;
   assign rsp_valid = validQ[ROM_LAT];
   assign rsp_id    = idQ[ROM_LAT];
   assign rsp_rgb   = rspRgbQ;

endmodule
